// File: rtl/spi_shift_engine_pkg.sv
// +--------------------------------------------------------------------+
// | spi_shift_engine_pkg : shared constants, state encodings, helpers   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package spi_shift_engine_pkg;

  // Mode constants of the earlier 8-bit mode-driven shift register
  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] LEFT  = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;
  localparam logic [1:0] PLOAD = 2'b11;

  typedef enum logic [1:0] {
    SS_IDLE  = 2'd0,
    SS_SHIFT = 2'd1,
    SS_DONE  = 2'd2
  } ss_state_t;

  // One spare bit above log2(width) so the count can reach WIDTH-1 for any WIDTH
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_engine_if.sv
// +--------------------------------------------------------------------+
// | spi_shift_engine_if : load handshake and receive-side bus          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface spi_shift_engine_if #(
  parameter int WIDTH = 8
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
`ifdef SPI_SHIFT_LSBFIRST_EN
  logic             lsb_first;
`endif
  logic             abort;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;

`ifdef SPI_SHIFT_LSBFIRST_EN
  modport master (
    output load_valid, load_data, lsb_first, abort,
    input  load_ready, rx_data, rx_valid, busy
  );
  modport slave (
    input  load_valid, load_data, lsb_first, abort,
    output load_ready, rx_data, rx_valid, busy
  );
`else
  modport master (
    output load_valid, load_data, abort,
    input  load_ready, rx_data, rx_valid, busy
  );
  modport slave (
    input  load_valid, load_data, abort,
    output load_ready, rx_data, rx_valid, busy
  );
`endif

endinterface

`default_nettype wire

// File: rtl/spi_bit_counter.sv
// +--------------------------------------------------------------------+
// | spi_bit_counter : clearable bit counter, terminal flag at WIDTH-1   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_bit_counter
  import spi_shift_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          clear,
  input  wire logic          inc,
  output logic      [CW-1:0] count,
  output logic               terminal
);

  assign terminal = (count == CW'(WIDTH - 1));

  // Saturates at the terminal value so the count can never wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_shift_engine.sv
// +--------------------------------------------------------------------+
// | spi_shift_engine : handshake-loaded SPI shift engine, rx word pulse |
// | Option macro SPI_SHIFT_LSBFIRST_EN adds per-transfer LSB-first.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_OUT = 1'b0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         sclk_rise,
  input  wire logic         sclk_fall,
  input  wire logic         serial_in,
  output logic              serial_out,
  spi_shift_engine_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  ss_state_t        r_state;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_hold;
  logic             r_out_en;
  logic             r_busy;
  logic             r_load_ready;
  logic             r_rx_valid;

  logic [CW-1:0]    w_count;
  logic             w_terminal;
  logic             w_load;
  logic             w_abort;
  logic             w_rise;
  logic             w_fall;
  logic             w_last;
  logic [WIDTH-1:0] w_tx_shift;
  logic [WIDTH-1:0] w_rx_word;
  logic             w_out_bit;

  assign w_load  = (r_state == SS_IDLE) && bus.load_valid && r_load_ready;
  assign w_abort = (r_state == SS_SHIFT) && bus.abort;
  assign w_rise  = (r_state == SS_SHIFT) && !bus.abort && sclk_rise;
  // A fall coinciding with a rise, or arriving before the first rise, is dropped
  assign w_fall  = (r_state == SS_SHIFT) && !bus.abort && sclk_fall && !sclk_rise
                   && (w_count != '0);
  assign w_last  = w_rise && w_terminal;

`ifdef SPI_SHIFT_LSBFIRST_EN
  logic r_lsb;

  always_comb begin
    if (r_lsb) begin
      w_tx_shift = {r_hold, r_tx[WIDTH-1:1]};
      w_rx_word  = {serial_in, r_tx[WIDTH-1:1]};
      w_out_bit  = r_tx[0];
    end else begin
      w_tx_shift = {r_tx[WIDTH-2:0], r_hold};
      w_rx_word  = {r_tx[WIDTH-2:0], serial_in};
      w_out_bit  = r_tx[WIDTH-1];
    end
  end
`else
  assign w_tx_shift = {r_tx[WIDTH-2:0], r_hold};
  assign w_rx_word  = {r_tx[WIDTH-2:0], serial_in};
  assign w_out_bit  = r_tx[WIDTH-1];
`endif

  spi_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_load || w_abort || w_last),
    .inc      (w_rise),
    .count    (w_count),
    .terminal (w_terminal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SS_IDLE;
      r_tx         <= '0;
      r_rx_data    <= '0;
      r_hold       <= 1'b0;
      r_out_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_load_ready <= 1'b0;
      r_rx_valid   <= 1'b0;
`ifdef SPI_SHIFT_LSBFIRST_EN
      r_lsb        <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        SS_IDLE: begin
          r_load_ready <= 1'b1;
          if (w_load) begin
            r_tx         <= bus.load_data;
`ifdef SPI_SHIFT_LSBFIRST_EN
            r_lsb        <= bus.lsb_first;
`endif
            r_out_en     <= 1'b1;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
            r_state      <= SS_SHIFT;
          end
        end
        SS_SHIFT: begin
          if (w_abort) begin
            r_out_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
            r_state      <= SS_IDLE;
          end else if (w_rise) begin
            r_hold <= serial_in;
            if (w_last) begin
              r_rx_data  <= w_rx_word;
              r_rx_valid <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= SS_DONE;
            end
          end else if (w_fall) begin
            r_tx <= w_tx_shift;
          end
        end
        SS_DONE: begin
          r_out_en     <= 1'b0;
          r_load_ready <= 1'b1;
          r_state      <= SS_IDLE;
        end
        default: begin
          r_state <= SS_IDLE;
        end
      endcase
    end
  end

  assign serial_out     = r_out_en ? w_out_bit : IDLE_OUT;
  assign bus.load_ready = r_load_ready;
  assign bus.busy       = r_busy;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.rx_data    = r_rx_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
// +--------------------------------------------------------------------+
// | tb_spi_shift_engine : directed self-checking bench for the engine  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_spi_shift_engine;

  logic clk;
  logic rst_n;
  logic sclk_rise;
  logic sclk_fall;
  logic serial_in;
  logic serial_out;
  logic loop_en;
  logic si_fix;
  int   total;
  int   bad;

  spi_shift_engine_if #(.WIDTH(8)) bus ();

  spi_shift_engine #(
    .WIDTH    (8),
    .IDLE_OUT (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk_rise  (sclk_rise),
    .sclk_fall  (sclk_fall),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .bus        (bus)
  );

  assign serial_in = loop_en ? serial_out : si_fix;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic r, input logic f);
    sclk_rise = r;
    sclk_fall = f;
    step();
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.load_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_wait", 32'(bus.load_ready), 32'd1);
  endtask

  // Offer a word; optionally keep load_valid asserted afterwards
  task automatic start_load(input logic [7:0] word, input logic keep_valid);
    wait_ready();
    bus.load_valid = 1'b1;
    bus.load_data  = word;
    step();
    bus.load_valid = keep_valid;
  endtask

  // Eight bits; bit both_at gets a combined rise+fall pulse. Returns in the DONE cycle.
  task automatic shift_bits(input int both_at, input logic pre_fall, output logic [7:0] seq);
    seq = 8'h00;
    if (pre_fall) pulse(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      seq = {seq[6:0], serial_out};
      pulse(1'b1, both_at == i);
      if (i < 7) pulse(1'b0, 1'b1);
    end
  endtask

  logic [7:0] seq;

  initial begin
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    sclk_rise      = 1'b0;
    sclk_fall      = 1'b0;
    loop_en        = 1'b1;
    si_fix         = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.abort      = 1'b0;
`ifdef SPI_SHIFT_LSBFIRST_EN
    bus.lsb_first  = 1'b0;
`endif
    step();
    step();

    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_rx_valid",   32'(bus.rx_valid),   32'd0);
    check("rst_rx_data",    32'(bus.rx_data),    32'h00);
    check("rst_serial_out", 32'(serial_out),     32'd0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 32'(bus.load_ready), 32'd1);

    // Loopback 0xA5, MSB first
    start_load(8'hA5, 1'b0);
    check("a5_busy",  32'(bus.busy),   32'd1);
    check("a5_first", 32'(serial_out), 32'd1);
    shift_bits(-1, 1'b0, seq);
    check("a5_rx_valid", 32'(bus.rx_valid),   32'd1);
    check("a5_rx_data",  32'(bus.rx_data),    32'hA5);
    check("a5_done_rdy", 32'(bus.load_ready), 32'd0);
    check("a5_done_bsy", 32'(bus.busy),       32'd0);
    check("a5_seq",      32'(seq),            32'hA5);
    step();
    check("a5_rx_pulse", 32'(bus.rx_valid),   32'd0);
    check("a5_ready_m2", 32'(bus.load_ready), 32'd1);

    // serial_in tied high, load zero
    loop_en = 1'b0;
    si_fix  = 1'b1;
    start_load(8'h00, 1'b0);
    shift_bits(-1, 1'b0, seq);
    check("ff_seq",     32'(seq),          32'h00);
    check("ff_rx_vld",  32'(bus.rx_valid), 32'd1);
    check("ff_rx_data", 32'(bus.rx_data),  32'hFF);
    loop_en = 1'b1;

    // Abort after three rises
    start_load(8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_busy",  32'(bus.busy),       32'd0);
    check("abort_ready", 32'(bus.load_ready), 32'd1);
    check("abort_sout",  32'(serial_out),     32'd0);
    check("abort_rxv",   32'(bus.rx_valid),   32'd0);
    check("abort_rxd",   32'(bus.rx_data),    32'hFF);
    step();
    check("abort_rxv2",  32'(bus.rx_valid),   32'd0);
    start_load(8'h5A, 1'b0);
    check("reload_busy", 32'(bus.busy), 32'd1);
    shift_bits(-1, 1'b0, seq);
    check("5a_rx_data",  32'(bus.rx_data), 32'h5A);
    check("5a_seq",      32'(seq),         32'h5A);
    step();

    // Back-to-back with load_valid held, then rise+fall and leading-fall on second word
    start_load(8'h96, 1'b1);
    shift_bits(-1, 1'b0, seq);
    check("b2b1_rx",    32'(bus.rx_data),  32'h96);
    check("b2b1_rxv",   32'(bus.rx_valid), 32'd1);
    bus.load_data = 8'h69;
    step();
    check("b2b_m2_rdy", 32'(bus.load_ready), 32'd1);
    check("b2b_m2_bsy", 32'(bus.busy),       32'd0);
    step();
    bus.load_valid = 1'b0;
    check("b2b_m3_bsy", 32'(bus.busy), 32'd1);
    shift_bits(2, 1'b1, seq);
    check("b2b2_seq",   32'(seq),          32'h69);
    check("b2b2_rxv",   32'(bus.rx_valid), 32'd1);
    check("b2b2_rx",    32'(bus.rx_data),  32'h69);
    step();

`ifdef SPI_SHIFT_LSBFIRST_EN
    // LSB-first 0x01; flipping lsb_first mid-transfer must not matter
    bus.lsb_first = 1'b1;
    start_load(8'h01, 1'b0);
    bus.lsb_first = 1'b0;
    shift_bits(-1, 1'b0, seq);
    check("lsb_seq", 32'(seq),         32'h80);
    check("lsb_rx",  32'(bus.rx_data), 32'h01);
    step();
`endif

    // Reset asserted mid-transfer
    start_load(8'hC3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(bus.busy),       32'd0);
    check("mid_rst_rdy",   32'(bus.load_ready), 32'd0);
    check("mid_rst_rxd",   32'(bus.rx_data),    32'h00);
    check("mid_rst_rxv",   32'(bus.rx_valid),   32'd0);
    check("mid_rst_sout",  32'(serial_out),     32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_rst_ready", 32'(bus.load_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
